dig_capture: RTL and testbench

- Receive-side companion to the free-running 8-bit counter timebase.
- Runs one single-slope conversion per request:
  - drives the analog `discharge` switch for a fixed time;
  - releases it and counts clock cycles until the analog comparator trips;
  - presents the captured count on a valid/ready output.
- Sits between the analog front end (comparator, discharge switch) and the digital readout/register logic.

---
 rtl/dig_capture.sv | 90 +++++++++
 tb/tb_dig_capture.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dig_capture.sv
// rtl/dig_capture.sv - single-slope conversion capture: timed discharge, then count until the comparator trips
module dig_capture #(
    parameter int WIDTH            = 8,
    parameter int DISCHARGE_CYCLES = 16,
    parameter int SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp,
    input  logic             ready,
    output logic             discharge,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             overflow
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DISCH = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [WIDTH-1:0] FULL     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] DIS_LAST = WIDTH'(DISCHARGE_CYCLES - 1);

    logic                   rst_q;
    logic [1:0]             state;
    logic [WIDTH-1:0]       counter;
    logic [SYNC_STAGES-1:0] sync;
    logic                   cmp_s;

    assign cmp_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    // Every output below is decoded from registered state, so inputs never reach outputs combinationally.
    always_ff @(posedge clk) begin
        if (rst_q) begin
            state    <= IDLE;
            counter  <= '0;
            sync     <= '0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], cmp};
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= DISCH;
                        counter  <= '0;
                        overflow <= 1'b0;
                    end
                end
                DISCH: begin
                    if (counter == DIS_LAST) begin
                        state   <= COUNT;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                COUNT: begin
                    // The comparator wins over saturation when both happen on the last count.
                    if (cmp_s) begin
                        data  <= counter;
                        state <= DONE;
                    end else if (counter == FULL) begin
                        data     <= FULL;
                        overflow <= 1'b1;
                        state    <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE: begin
                    if (ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign discharge = (state == DISCH);
    assign busy      = (state != IDLE);
    assign valid     = (state == DONE);
endmodule

// File: tb/tb_dig_capture.sv
// tb/tb_dig_capture.sv - scenario-driven scoreboard bench for dig_capture
module tb_dig_capture;
    logic       clk = 1'b0;
    logic       reset, start, cmp, ready;
    logic       discharge, busy, valid, overflow;
    logic [7:0] data;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    dig_capture #(.WIDTH(8), .DISCHARGE_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .cmp(cmp), .ready(ready),
        .discharge(discharge), .busy(busy), .valid(valid), .data(data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
    endtask

    // Pulses start and walks through DISCHARGE, ending at the first COUNT cycle (counter = 0).
    task automatic run_discharge(output int dis);
        start = 1'b1;
        tick();
        start = 1'b0;
        dis = 0;
        while (discharge === 1'b1 && dis < 100) begin
            dis++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; ready = 1'b1; cmp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmp = ~cmp;
            tick();
        end
        checks++;
        if ({discharge, busy, valid, data, overflow} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: dis=%b busy=%b valid=%b data=%h ovf=%b required all zero",
                     discharge, busy, valid, data, overflow);
        end
        reset = 1'b0; start = 1'b0; cmp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || discharge !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: busy=%b dis=%b required 0 0", busy, discharge);
            end
        end
    endtask

    task automatic test_nominal();
        int dis, n;
        ready = 1'b1; cmp = 1'b0;
        run_discharge(dis);
        checks++;
        if (dis != 16) begin
            failures++;
            $display("FAIL nominal_discharge_len: got %0d required 16", dis);
        end
        sb.push_back('{d: 8'h28, o: 1'b0});
        repeat (38) tick();
        cmp = 1'b1;
        wait_valid(n);
        checks++;
        if (valid !== 1'b1 || n != 3) begin
            failures++;
            $display("FAIL nominal_latency: valid=%b cycles=%0d required 1 3", valid, n);
        end
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (data !== e.d || overflow !== e.o) begin
            failures++;
            $display("FAIL nominal_result: data=%h ovf=%b required %h %b", data, overflow, e.d, e.o);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL nominal_release: valid=%b busy=%b required 0 0", valid, busy);
        end
        cmp = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        int dis, n;
        ready = 1'b1; cmp = 1'b0;
        run_discharge(dis);
        sb.push_back('{d: 8'hFF, o: 1'b1});
        wait_valid(n);
        checks++;
        if (valid !== 1'b1 || n != 256) begin
            failures++;
            $display("FAIL overflow_latency: valid=%b cycles=%0d required 1 256", valid, n);
        end
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (data !== e.d || overflow !== e.o) begin
            failures++;
            $display("FAIL overflow_result: data=%h ovf=%b required %h %b", data, overflow, e.d, e.o);
        end
        tick();
        checks++;
        if (overflow !== 1'b1 || data !== 8'hFF) begin
            failures++;
            $display("FAIL overflow_hold: ovf=%b data=%h required 1 ff", overflow, data);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || discharge !== 1'b1) begin
            failures++;
            $display("FAIL overflow_clear: ovf=%b dis=%b required 0 1", overflow, discharge);
        end
        wait_valid(n);
        tick();
    endtask

    task automatic test_backpressure();
        int dis, n;
        ready = 1'b0; cmp = 1'b0;
        run_discharge(dis);
        sb.push_back('{d: 8'h28, o: 1'b0});
        repeat (38) tick();
        cmp = 1'b1;
        wait_valid(n);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || discharge !== 1'b0 || data !== e.d || overflow !== e.o) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: valid=%b busy=%b dis=%b data=%h ovf=%b required 1 1 0 %h %b",
                         i, valid, busy, discharge, data, overflow, e.d, e.o);
            end
            start = (i % 2 == 0);
            cmp = (i % 3 == 0);
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== e.d) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b busy=%b data=%h required 0 0 %h", valid, busy, data, e.d);
        end
        cmp = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int dis, n;
        ready = 1'b1; cmp = 1'b0;
        run_discharge(dis);
        repeat (100) tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_valid[%0d]: valid=%b required 0", i, valid);
            end
        end
        checks++;
        if (busy !== 1'b0 || discharge !== 1'b0 || data !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state: busy=%b dis=%b data=%h ovf=%b required 0 0 00 0",
                     busy, discharge, data, overflow);
        end
        reset = 1'b0;
        repeat (2) tick();
        run_discharge(dis);
        sb.push_back('{d: 8'd22, o: 1'b0});
        repeat (20) tick();
        cmp = 1'b1;
        wait_valid(n);
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (valid !== 1'b1 || dis != 16 || data !== e.d || overflow !== e.o) begin
            failures++;
            $display("FAIL reset_mid_rerun: valid=%b dis=%0d data=%h ovf=%b required 1 16 %h %b",
                     valid, dis, data, overflow, e.d, e.o);
        end
        tick();
        cmp = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_early_cmp();
        int dis;
        ready = 1'b1; cmp = 1'b1;
        repeat (3) tick();
        run_discharge(dis);
        sb.push_back('{d: 8'h00, o: 1'b0});
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL early_count_entry: busy=%b valid=%b required 1 0", busy, valid);
        end
        tick();
        checks++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (valid !== 1'b1 || data !== e.d || overflow !== e.o) begin
            failures++;
            $display("FAIL early_result: valid=%b data=%h ovf=%b required 1 %h %b", valid, data, overflow, e.d, e.o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        ready = 1'b1; cmp = 1'b1; start = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (discharge !== 1'b1) begin
                failures++;
                $display("FAIL b2b_start[%0d]: dis=%b required 1", i, discharge);
            end
            sb.push_back('{d: 8'h00, o: 1'b0});
            wait_valid(n);
            checks++;
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            if (valid !== 1'b1 || n != 17 || data !== e.d || overflow !== e.o) begin
                failures++;
                $display("FAIL b2b_result[%0d]: valid=%b cycles=%0d data=%h ovf=%b required 1 17 %h %b",
                         i, valid, n, data, overflow, e.d, e.o);
            end
            tick();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_gap[%0d]: busy=%b required 0", i, busy);
            end
            tick();
        end
        start = 1'b0;
        wait_valid(n);
        tick();
        cmp = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cmp = 1'b0; ready = 1'b0;
        test_reset();
        test_nominal();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_early_cmp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
